// File: rtl/mem_bus_pkg.sv
// Shared types for the two-master memory bus arbiter: FSM states, request
// kinds, master indices and the tie-aware master selection helper.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_RD_WAIT = 2'd1,
    ARB_WR_DONE = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_RD = 1'b0,
    REQ_WR = 1'b1
  } req_kind_e;

  localparam logic MST_CPU = 1'b0;
  localparam logic MST_DMA = 1'b1;

  function automatic logic pick_master(input logic v0, input logic v1, input logic tie_winner);
    logic sel;
    if (v0 && v1) begin
      sel = tie_winner;
    end else if (v1) begin
      sel = MST_DMA;
    end else begin
      sel = MST_CPU;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mem_bus_port.sv
// Per-master front end: one pending request slot, drop rules for protocol
// violations, ready generation and the read-data hold register.
module mem_bus_port
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              rd_req_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              grant_i,
  input  logic              rd_done_i,
  input  logic              wr_done_i,
  input  logic [DATA_W-1:0] mem_rd_data_i,
  output logic              req_valid_o,
  output req_kind_e         req_kind_o,
  output logic [ADDR_W-1:0] req_addr_o,
  output logic [DATA_W-1:0] req_data_o,
  output logic              ready_o,
  output logic [DATA_W-1:0] rd_data_o
);

  logic              pend_q, pend_d;
  req_kind_e         kind_q, kind_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              accept_s;
  req_kind_e         new_kind_s;

  // Offer the pending request (or a fresh pulse, for bypass) and compute slot/ready updates.
  always_comb begin
    // Pulses while busy are dropped; a simultaneous rd+wr is a write.
    accept_s   = (rd_req_i | wr_en_i) & ready_q;
    new_kind_s = wr_en_i ? REQ_WR : REQ_RD;
    if (pend_q) begin
      req_kind_o = kind_q;
      req_addr_o = addr_q;
      req_data_o = data_q;
    end else begin
      req_kind_o = new_kind_s;
      req_addr_o = addr_i;
      req_data_o = wr_data_i;
    end
    req_valid_o = pend_q | accept_s;

    pend_d    = pend_q;
    kind_d    = kind_q;
    addr_d    = addr_q;
    data_d    = data_q;
    ready_d   = ready_q;
    rd_data_d = rd_data_q;
    if (accept_s) begin
      kind_d  = new_kind_s;
      addr_d  = addr_i;
      data_d  = wr_data_i;
      pend_d  = ~grant_i;
      ready_d = 1'b0;
    end else if (grant_i) begin
      pend_d = 1'b0;
    end else if (rd_done_i) begin
      ready_d   = 1'b1;
      rd_data_d = mem_rd_data_i;
    end else if (wr_done_i) begin
      ready_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end

  // Slot, ready and read-data registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_q    <= 1'b0;
      kind_q    <= REQ_RD;
      addr_q    <= {ADDR_W{1'b0}};
      data_q    <= {DATA_W{1'b0}};
      ready_q   <= 1'b1;
      rd_data_q <= {DATA_W{1'b0}};
    end else begin
      pend_q    <= pend_d;
      kind_q    <= kind_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign ready_o   = ready_q;
  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master memory bus arbiter (CPU = m0, DMA/video = m1).
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; default is fixed m1 priority.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic              m0_rd_req_i,
  input  logic              m0_wr_en_i,
  input  logic [DATA_W-1:0] m0_wr_data_i,
  output logic [DATA_W-1:0] m0_rd_data_o,
  output logic              m0_ready_o,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic              m1_rd_req_i,
  input  logic              m1_wr_en_i,
  input  logic [DATA_W-1:0] m1_wr_data_i,
  output logic [DATA_W-1:0] m1_rd_data_o,
  output logic              m1_ready_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_req_o,
  output logic              mem_wr_en_o,
  output logic [DATA_W-1:0] mem_wr_data_o,
  input  logic [DATA_W-1:0] mem_rd_data_i,
  input  logic              mem_ready_i
);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              mem_rd_req_q, mem_rd_req_d;
  logic              mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wr_data_q, mem_wr_data_d;

  logic [1:0]        req_valid_s;
  req_kind_e         req_kind_s [2];
  logic [ADDR_W-1:0] req_addr_s [2];
  logic [DATA_W-1:0] req_data_s [2];
  logic [1:0]        grant_s;
  logic [1:0]        rd_done_s;
  logic [1:0]        wr_done_s;
  logic              sel_s;
  logic              tie_winner_s;

  mem_bus_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port0 (
    .clk           (clk),
    .reset_n       (reset_n),
    .addr_i        (m0_addr_i),
    .rd_req_i      (m0_rd_req_i),
    .wr_en_i       (m0_wr_en_i),
    .wr_data_i     (m0_wr_data_i),
    .grant_i       (grant_s[0]),
    .rd_done_i     (rd_done_s[0]),
    .wr_done_i     (wr_done_s[0]),
    .mem_rd_data_i (mem_rd_data_i),
    .req_valid_o   (req_valid_s[0]),
    .req_kind_o    (req_kind_s[0]),
    .req_addr_o    (req_addr_s[0]),
    .req_data_o    (req_data_s[0]),
    .ready_o       (m0_ready_o),
    .rd_data_o     (m0_rd_data_o)
  );

  mem_bus_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port1 (
    .clk           (clk),
    .reset_n       (reset_n),
    .addr_i        (m1_addr_i),
    .rd_req_i      (m1_rd_req_i),
    .wr_en_i       (m1_wr_en_i),
    .wr_data_i     (m1_wr_data_i),
    .grant_i       (grant_s[1]),
    .rd_done_i     (rd_done_s[1]),
    .wr_done_i     (wr_done_s[1]),
    .mem_rd_data_i (mem_rd_data_i),
    .req_valid_o   (req_valid_s[1]),
    .req_kind_o    (req_kind_s[1]),
    .req_addr_o    (req_addr_s[1]),
    .req_data_o    (req_data_s[1]),
    .ready_o       (m1_ready_o),
    .rd_data_o     (m1_rd_data_o)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q;

  // Remember the most recent grant so the other master wins the next tie.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant_q <= MST_DMA;
    end else if (|grant_s) begin
      last_grant_q <= sel_s;
    end else begin
      last_grant_q <= last_grant_q;
    end
  end

  assign tie_winner_s = ~last_grant_q;
`else
  assign tie_winner_s = MST_DMA;
`endif

  // Arbiter next-state, grant and memory-bus drive.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    mem_rd_req_d  = 1'b0;
    mem_wr_en_d   = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    grant_s       = 2'b00;
    rd_done_s     = 2'b00;
    wr_done_s     = 2'b00;
    sel_s         = pick_master(req_valid_s[0], req_valid_s[1], tie_winner_s);
    case (state_q)
      ARB_IDLE: begin
        if (mem_ready_i && (|req_valid_s)) begin
          grant_s[sel_s] = 1'b1;
          owner_d        = sel_s;
          mem_addr_d     = req_addr_s[sel_s];
          if (req_kind_s[sel_s] == REQ_WR) begin
            mem_wr_en_d   = 1'b1;
            mem_wr_data_d = req_data_s[sel_s];
            state_d       = ARB_WR_DONE;
          end else begin
            mem_rd_req_d = 1'b1;
            state_d      = ARB_RD_WAIT;
          end
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_RD_WAIT: begin
        // The issue cycle itself still shows the stale mem_ready, so skip it.
        if (mem_ready_i && !mem_rd_req_q) begin
          rd_done_s[owner_q] = 1'b1;
          state_d            = ARB_IDLE;
        end else begin
          state_d = ARB_RD_WAIT;
        end
      end
      ARB_WR_DONE: begin
        wr_done_s[owner_q] = 1'b1;
        state_d            = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // FSM and memory-bus output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ARB_IDLE;
      owner_q       <= MST_CPU;
      mem_rd_req_q  <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_addr_q    <= {ADDR_W{1'b0}};
      mem_wr_data_q <= {DATA_W{1'b0}};
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      mem_rd_req_q  <= mem_rd_req_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
    end
  end

  assign mem_rd_req_o  = mem_rd_req_q;
  assign mem_wr_en_o   = mem_wr_en_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wr_data_o = mem_wr_data_q;

endmodule
